// File: rtl/wb_regfile_pkg.sv
// Shared types and constants for the NPC writeback stage and register file.
// Register/index widths derive from REG_BUS and REG_ADDR_BUS.
package wb_regfile_pkg;

  localparam int unsigned REG_BUS      = 64;
  localparam int unsigned REG_ADDR_BUS = 5;
  localparam int unsigned XLEN         = REG_BUS;
  localparam int unsigned AW           = REG_ADDR_BUS;
  localparam int unsigned NREG         = 1 << AW;
  localparam int unsigned CNT_W        = 64;

  localparam logic [XLEN-1:0] ZERO_WORD   = '0;
  localparam logic [AW-1:0]   ZERO_REG    = '0;
  localparam logic            RST_ENABLE  = 1'b0;
  localparam logic            RST_DISABLE = 1'b1;

  // Writeback bundle held between capture and commit
  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   wd;
    logic            wreg;
    logic [XLEN-1:0] wdata;
  } wb_bundle_t;

endpackage

// File: rtl/wb_regfile_if.sv
// Writeback bundle, decode read ports and retire count between the core and wb_regfile.
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  logic             wb_valid_i;
  logic [AW-1:0]    wd_i;
  logic             wreg_i;
  logic [XLEN-1:0]  wdata_i;
  logic             flush_i;
  logic [AW-1:0]    raddr1_i;
  logic [AW-1:0]    raddr2_i;
  logic [XLEN-1:0]  rdata1_o;
  logic [XLEN-1:0]  rdata2_o;
  logic             hazard_o;
  logic [CNT_W-1:0] instret_o;

  modport master (
    output wb_valid_i, wd_i, wreg_i, wdata_i, flush_i, raddr1_i, raddr2_i,
    input  rdata1_o, rdata2_o, hazard_o, instret_o
  );

  modport slave (
    input  wb_valid_i, wd_i, wreg_i, wdata_i, flush_i, raddr1_i, raddr2_i,
    output rdata1_o, rdata2_o, hazard_o, instret_o
  );

endinterface

// File: rtl/wb_regfile_gpr_array.sv
// General-purpose register storage: one synchronous write port, two combinational
// read ports, x0 never written and always read as zero.
module wb_regfile_gpr_array
  import wb_regfile_pkg::*;
#(
  parameter int unsigned XLEN_P = XLEN,
  parameter int unsigned NREG_P = NREG,
  parameter int unsigned AW_P   = AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW_P-1:0]   waddr_i,
  input  logic [XLEN_P-1:0] wdata_i,
  input  logic [AW_P-1:0]   raddr1_i,
  input  logic [AW_P-1:0]   raddr2_i,
  output logic [XLEN_P-1:0] rdata1_o,
  output logic [XLEN_P-1:0] rdata2_o
);

  logic [XLEN_P-1:0] mem_q [NREG_P];

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n != RST_DISABLE) begin
      for (int unsigned i = 0; i < NREG_P; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: captures the ALU bundle into wb_q, commits it to the GPR array next
// edge, forwards or flags the pending write on reads, counts retired bundles.
// Optional macro REGFILE_BYPASS_EN: forward wb_q to read ports instead of raising hazard_o.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  wb_regfile_if.slave  bus
);

  wb_bundle_t       wb_q, wb_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             commit_we;
  logic [XLEN-1:0]  arr_rdata1, arr_rdata2;
  logic             hit1, hit2;

  function automatic logic pend_hit(input wb_bundle_t b, input logic [AW-1:0] ra);
    return b.valid && b.wreg && (b.wd == ra) && (ra != ZERO_REG);
  endfunction

  always_comb begin
    wb_d       = '0;
    wb_d.valid = bus.wb_valid_i & ~bus.flush_i;
    wb_d.wd    = bus.wd_i;
    wb_d.wreg  = bus.wreg_i;
    wb_d.wdata = bus.wdata_i;
    instret_d  = instret_q + CNT_W'(wb_q.valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ENABLE) begin
      wb_q      <= '0;
      instret_q <= '0;
    end else begin
      wb_q      <= wb_d;
      instret_q <= instret_d;
    end
  end

  assign commit_we = wb_q.valid & wb_q.wreg & (wb_q.wd != ZERO_REG);

  wb_regfile_gpr_array #(
    .XLEN_P (XLEN),
    .NREG_P (NREG),
    .AW_P   (AW)
  ) u_gpr_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (commit_we),
    .waddr_i  (wb_q.wd),
    .wdata_i  (wb_q.wdata),
    .raddr1_i (bus.raddr1_i),
    .raddr2_i (bus.raddr2_i),
    .rdata1_o (arr_rdata1),
    .rdata2_o (arr_rdata2)
  );

  assign hit1 = pend_hit(wb_q, bus.raddr1_i);
  assign hit2 = pend_hit(wb_q, bus.raddr2_i);

`ifdef REGFILE_BYPASS_EN
  assign bus.rdata1_o = hit1 ? wb_q.wdata : arr_rdata1;
  assign bus.rdata2_o = hit2 ? wb_q.wdata : arr_rdata2;
  assign bus.hazard_o = 1'b0;
`else
  assign bus.rdata1_o = arr_rdata1;
  assign bus.rdata2_o = arr_rdata2;
  assign bus.hazard_o = hit1 | hit2;
`endif

  assign bus.instret_o = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized bench for wb_regfile against an array/pending-write reference model.
// Works with or without REGFILE_BYPASS_EN defined.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  wb_regfile_if bus();

  wb_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state: architectural registers plus one pending write
  logic [63:0] m_regs [32];
  logic        m_pv, m_pw;
  logic [4:0]  m_pwd;
  logic [63:0] m_pdata;
  logic [63:0] m_inst;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_pv = 1'b0; m_pw = 1'b0; m_pwd = 5'd0; m_pdata = 64'd0; m_inst = 64'd0;
  endfunction

  function automatic logic model_hit(input logic [4:0] ra);
    return m_pv && m_pw && (m_pwd == ra) && (ra != 5'd0);
  endfunction

  function automatic logic [63:0] model_read(input logic [4:0] ra);
    if (ra == 5'd0) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (model_hit(ra)) return m_pdata;
`endif
    return m_regs[ra];
  endfunction

  function automatic logic model_hazard(input logic [4:0] r1, input logic [4:0] r2);
`ifdef REGFILE_BYPASS_EN
    return 1'b0;
`else
    return model_hit(r1) || model_hit(r2);
`endif
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".rd1"}, bus.rdata1_o, model_read(bus.raddr1_i));
    check({tag, ".rd2"}, bus.rdata2_o, model_read(bus.raddr2_i));
    check({tag, ".haz"}, 64'(bus.hazard_o), 64'(model_hazard(bus.raddr1_i, bus.raddr2_i)));
    check({tag, ".inst"}, bus.instret_o, m_inst);
  endtask

  // One clock: drive after negedge, check mid-cycle, advance model at posedge
  task automatic cycle(input string tag, input logic v, input logic [4:0] wd, input logic wr,
                       input logic [63:0] wdata, input logic fl,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    bus.wb_valid_i = v; bus.wd_i = wd; bus.wreg_i = wr; bus.wdata_i = wdata;
    bus.flush_i = fl; bus.raddr1_i = r1; bus.raddr2_i = r2;
    #1;
    check_outputs(tag);
    @(posedge clk);
    if (m_pv && m_pw && m_pwd != 5'd0) m_regs[m_pwd] = m_pdata;
    if (m_pv) m_inst = m_inst + 64'd1;
    m_pv = v & ~fl; m_pw = wr; m_pwd = wd; m_pdata = wdata;
  endtask

  task automatic idle(input string tag, input logic [4:0] r1, input logic [4:0] r2);
    cycle(tag, 1'b0, 5'd0, 1'b0, 64'd0, 1'b0, r1, r2);
  endtask

  initial begin
    bus.wb_valid_i = 1'b0; bus.wd_i = '0; bus.wreg_i = 1'b0; bus.wdata_i = '0;
    bus.flush_i = 1'b0; bus.raddr1_i = '0; bus.raddr2_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.rd1", bus.rdata1_o, 64'd0);
    check("rst.haz", 64'(bus.hazard_o), 64'd0);
    check("rst.inst", bus.instret_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic commit and bypass/hazard on x3
    cycle("basic.c0", 1'b1, 5'd3, 1'b1, 64'hDEAD_BEEF, 1'b0, 5'd3, 5'd0);
    idle("basic.c1", 5'd3, 5'd3);
    idle("basic.c2", 5'd3, 5'd0);
    check("basic.x3", bus.rdata1_o, 64'hDEAD_BEEF);
    check("basic.inst", bus.instret_o, 64'd1);

    // x0 protection
    cycle("x0.c0", 1'b1, 5'd0, 1'b1, 64'hFFFF, 1'b0, 5'd0, 5'd0);
    idle("x0.c1", 5'd0, 5'd0);
    check("x0.haz", 64'(bus.hazard_o), 64'd0);
    idle("x0.c2", 5'd0, 5'd0);
    check("x0.rd", bus.rdata1_o, 64'd0);

    // Flush and no-write bundles
    cycle("flush.c0", 1'b1, 5'd9, 1'b1, 64'h55, 1'b1, 5'd9, 5'd0);
    cycle("nowr.c0", 1'b1, 5'd10, 1'b0, 64'h66, 1'b0, 5'd9, 5'd10);
    idle("nowr.c1", 5'd9, 5'd10);
    idle("nowr.c2", 5'd9, 5'd10);
    check("nowr.x9", bus.rdata1_o, 64'd0);
    check("nowr.x10", bus.rdata2_o, 64'd0);
    check("nowr.inst", bus.instret_o, 64'd3);

    // Back-to-back writes to x7
    cycle("b2b.c0", 1'b1, 5'd7, 1'b1, 64'd1, 1'b0, 5'd0, 5'd7);
    cycle("b2b.c1", 1'b1, 5'd7, 1'b1, 64'd2, 1'b0, 5'd0, 5'd7);
    cycle("b2b.c2", 1'b1, 5'd7, 1'b1, 64'd3, 1'b0, 5'd0, 5'd7);
    idle("b2b.c3", 5'd7, 5'd7);
    idle("b2b.c4", 5'd7, 5'd7);
    check("b2b.x7", bus.rdata2_o, 64'd3);

    // Reset asserted in the commit cycle of a pending x5 write
    cycle("rstmid.c0", 1'b1, 5'd5, 1'b1, 64'h1234, 1'b0, 5'd5, 5'd5);
    @(negedge clk);
    bus.wb_valid_i = 1'b0; bus.wreg_i = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rstmid.x5", bus.rdata1_o, 64'd0);
    check("rstmid.haz", 64'(bus.hazard_o), 64'd0);
    check("rstmid.inst", bus.instret_o, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle("rstmid.c2", 5'd5, 5'd3);

    // Randomized traffic, indices biased low to provoke pending-write hits
    for (int n = 0; n < 1500; n++) begin
      logic        v, wr, fl;
      logic [4:0]  wd, r1, r2;
      logic [63:0] wdata;
      v     = ($urandom_range(0, 3) != 0);
      wr    = ($urandom_range(0, 4) != 0);
      fl    = ($urandom_range(0, 7) == 0);
      wd    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      r1    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      r2    = ($urandom_range(0, 2) == 0) ? wd : 5'($urandom_range(0, 7));
      wdata = {32'($urandom), 32'($urandom)};
      cycle("rand", v, wd, wr, wdata, fl, r1, r2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
